// File: rtl/instr_fetch_seq.sv
// Fetch/decode sequencer: owns program memory and PC, resolves conditional jumps locally and
// issues ALU instructions to execute over valid/ready. Optional counters: INSTR_FETCH_PERF_CNT_EN.
module instr_fetch_seq #(
  parameter  int unsigned PROG_DEPTH = 16,
  parameter  int unsigned IW         = 32,
  localparam int unsigned AW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  output logic [IW-1:0] ir_out,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          exec_done,
  input  logic          sign_in,
  input  logic          zero_in,
  input  logic          overflow_in,
  input  logic          carry_in,
  output logic [AW-1:0] pc_out,
  output logic          busy,
`ifdef INSTR_FETCH_PERF_CNT_EN
  output logic          halted,
  output logic [31:0]   retired_cnt,
  output logic [31:0]   cycle_cnt
`else
  output logic          halted
`endif
);

  localparam int unsigned OPW = 5;
  localparam int unsigned CW  = 32;

  localparam logic [OPW-1:0] OP_JMP   = 5'b10000;
  localparam logic [OPW-1:0] OP_JC    = 5'b10001;
  localparam logic [OPW-1:0] OP_JNC   = 5'b10010;
  localparam logic [OPW-1:0] OP_JS    = 5'b10011;
  localparam logic [OPW-1:0] OP_JNS   = 5'b10100;
  localparam logic [OPW-1:0] OP_JZ    = 5'b10101;
  localparam logic [OPW-1:0] OP_JNZ   = 5'b10110;
  localparam logic [OPW-1:0] OP_JO    = 5'b10111;
  localparam logic [OPW-1:0] OP_JNO   = 5'b11000;
  localparam logic [OPW-1:0] OP_HALT  = 5'b11001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_e;

  typedef struct packed {
    logic s;
    logic z;
    logic o;
    logic c;
  } flags_t;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [IW-1:0]  ir_reg_q;
  logic [IW-1:0]  ir_out_q, ir_out_d;
  logic           ir_valid_q, ir_valid_d;
  logic           halted_q, halted_d;
  logic           busy_q, busy_d;
  flags_t         flags_q, flags_d;

  logic [IW-1:0]  mem_q [PROG_DEPTH];
  logic [OPW-1:0] opcode;
  logic           is_branch;
  logic           is_halt;
  logic           br_taken;
  logic           prog_ok;

  assign opcode  = ir_reg_q[IW-1 -: OPW];
  assign is_halt = (opcode == OP_HALT);
  assign prog_ok = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

  // Program memory: loads only while parked; synchronous read in FETCH.
  always_ff @(posedge clk) begin
    if (prog_ok) begin
      mem_q[prog_addr] <= prog_data;
    end
    if (state_q == S_FETCH) begin
      ir_reg_q <= mem_q[pc_q];
    end
  end

  // Branch classification and condition evaluation against the latched flags.
  always_comb begin
    is_branch = 1'b1;
    br_taken  = 1'b0;
    case (opcode)
      OP_JMP:  br_taken = 1'b1;
      OP_JC:   br_taken = flags_q.c;
      OP_JNC:  br_taken = !flags_q.c;
      OP_JS:   br_taken = flags_q.s;
      OP_JNS:  br_taken = !flags_q.s;
      OP_JZ:   br_taken = flags_q.z;
      OP_JNZ:  br_taken = !flags_q.z;
      OP_JO:   br_taken = flags_q.o;
      OP_JNO:  br_taken = !flags_q.o;
      default: is_branch = 1'b0;
    endcase
  end

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_out_d   = ir_out_q;
    ir_valid_d = ir_valid_q;
    flags_d    = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_branch) begin
          pc_d    = br_taken ? ir_reg_q[AW-1:0] : pc_q + AW'(1);
          state_d = S_FETCH;
        end else begin
          ir_out_d   = ir_reg_q;
          ir_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (exec_done) begin
          flags_d = '{s: sign_in, z: zero_in, o: overflow_in, c: carry_in};
          pc_d    = pc_q + AW'(1);
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          flags_d = '0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    halted_d = (state_d == S_HALT);
    busy_d   = state_d inside {S_FETCH, S_DECODE, S_ISSUE, S_WAIT};
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_out_q   <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_out_q   <= ir_out_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
      flags_q    <= flags_d;
    end
  end

  assign ir_out   = ir_out_q;
  assign ir_valid = ir_valid_q;
  assign pc_out   = pc_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [CW-1:0] retired_q, retired_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic          retire_evt;

  // Saturating counters; a restart from HALT begins a fresh measurement.
  always_comb begin
    retire_evt = ((state_q == S_DECODE) && is_branch) || ((state_q == S_WAIT) && exec_done);
    retired_d  = retired_q;
    cycle_d    = cycle_q;
    if ((state_q == S_HALT) && start) begin
      retired_d = '0;
      cycle_d   = '0;
    end else begin
      if (retire_evt && (retired_q != '1)) begin
        retired_d = retired_q + CW'(1);
      end
      if (busy_q && (cycle_q != '1)) begin
        cycle_d = cycle_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      retired_q <= retired_d;
      cycle_q   <= cycle_d;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Randomized self-checking bench for instr_fetch_seq against an instruction-level reference model.
module tb_instr_fetch_seq;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic [31:0]   ir_out;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic          exec_done = 1'b0;
  logic          sign_in = 1'b0;
  logic          zero_in = 1'b0;
  logic          overflow_in = 1'b0;
  logic          carry_in = 1'b0;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          halted;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0]   retired_cnt;
  logic [31:0]   cycle_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_seq #(.PROG_DEPTH(DEPTH), .IW(32)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ir_out(ir_out), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .exec_done(exec_done), .sign_in(sign_in), .zero_in(zero_in),
    .overflow_in(overflow_in), .carry_in(carry_in), .pc_out(pc_out), .busy(busy),
`ifdef INSTR_FETCH_PERF_CNT_EN
    .halted(halted), .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`else
    .halted(halted)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  // Reference model: instruction memory, PC, flags {s,z,o,c} and counters.
  logic [31:0] mem_m [DEPTH];
  logic [AW-1:0] pc_m;
  logic [3:0]  fl_m;
  int unsigned ret_m;
  int unsigned cyc_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [15:0] imm);
    logic [10:0] mid;
    mid = 11'($urandom);
    return {op, mid, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 99);
    if (r < 8)       w[31:27] = 5'b11001;
    else if (r < 50) w[31:27] = 5'($urandom_range(16, 24));
    else if (r < 90) w[31:27] = 5'($urandom_range(0, 15));
    else             w[31:27] = 5'($urandom_range(26, 31));
    return w;
  endfunction

  function automatic bit br_taken(input logic [4:0] op, input logic [3:0] f);
    case (op)
      5'b10000: return 1'b1;
      5'b10001: return f[0];
      5'b10010: return !f[0];
      5'b10011: return f[3];
      5'b10100: return !f[3];
      5'b10101: return f[2];
      5'b10110: return !f[2];
      5'b10111: return f[1];
      5'b11000: return !f[1];
      default:  return 1'b0;
    endcase
  endfunction

  task automatic model_restart();
    pc_m  = '0;
    fl_m  = '0;
    ret_m = 0;
    cyc_m = 0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    model_restart();
  endtask

  task automatic load(input int addr, input logic [31:0] data, input bit with_start);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = data;
    start     = with_start;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    mem_m[addr] = data;
    if (with_start) model_restart();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_restart();
  endtask

  // Runs the instruction at the model PC; entry point is the first FETCH cycle.
  task automatic exec_one(input int k, input int d, input logic [3:0] fl, input bit early,
                          input bit poke, output bit hlt);
    logic [31:0]   ins;
    logic [4:0]    op;
    logic [AW-1:0] npc;
    int            dd;
    ins = mem_m[pc_m];
    op  = ins[31:27];
    hlt = 1'b0;
    checks++;
    if (pc_out !== pc_m || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_pc pc=%0d busy=%0b expected pc=%0d busy=1", pc_out, busy, pc_m);
    end
    if (op == 5'b11001) begin
      tick();
      tick();
      cyc_m += 2;
      hlt = 1'b1;
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || pc_out !== pc_m || ir_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt halted=%0b busy=%0b pc=%0d expected halted=1 busy=0 pc=%0d",
                 halted, busy, pc_out, pc_m);
      end
`ifdef INSTR_FETCH_PERF_CNT_EN
      checks++;
      if (retired_cnt !== ret_m || cycle_cnt !== cyc_m) begin
        errors++;
        $display("FAIL perf_at_halt retired=%0d cycles=%0d expected %0d %0d",
                 retired_cnt, cycle_cnt, ret_m, cyc_m);
      end
`endif
    end else if (op >= 5'b10000 && op <= 5'b11000) begin
      npc = br_taken(op, fl_m) ? ins[AW-1:0] : pc_m + AW'(1);
      tick();
      checks++;
      if (ir_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL branch_decode ir_valid=%0b busy=%0b expected 0 1", ir_valid, busy);
      end
      tick();
      pc_m = npc;
      ret_m++;
      cyc_m += 2;
      checks++;
      if (ir_valid !== 1'b0 || pc_out !== npc) begin
        errors++;
        $display("FAIL branch_target op=%b ir_valid=%0b pc=%0d expected 0 pc=%0d",
                 op, ir_valid, pc_out, npc);
      end
    end else begin
      tick();
      tick();
      checks++;
      if (ir_valid !== 1'b1 || ir_out !== ins) begin
        errors++;
        $display("FAIL issue ir_valid=%0b ir_out=%h expected 1 %h", ir_valid, ir_out, ins);
      end
      for (int i = 0; i < k; i++) begin
        tick();
        checks++;
        if (ir_valid !== 1'b1 || ir_out !== ins) begin
          errors++;
          $display("FAIL backpressure cyc=%0d ir_valid=%0b ir_out=%h expected 1 %h",
                   i, ir_valid, ir_out, ins);
        end
      end
      ir_ready = 1'b1;
      if (early) begin
        exec_done = 1'b1;
        {sign_in, zero_in, overflow_in, carry_in} = ~fl;
      end
      tick();
      ir_ready  = 1'b0;
      exec_done = 1'b0;
      checks++;
      if (ir_valid !== 1'b0 || busy !== 1'b1 || pc_out !== pc_m) begin
        errors++;
        $display("FAIL handshake ir_valid=%0b busy=%0b pc=%0d expected 0 1 %0d",
                 ir_valid, busy, pc_out, pc_m);
      end
      dd = (poke && d == 0) ? 1 : d;
      for (int i = 0; i < dd; i++) begin
        if (poke && i == 0) begin
          npc       = pc_m + AW'(1);
          start     = 1'b1;
          prog_we   = 1'b1;
          prog_addr = npc;
          prog_data = ~mem_m[npc];
        end
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        checks++;
        if (pc_out !== pc_m || busy !== 1'b1 || ir_valid !== 1'b0) begin
          errors++;
          $display("FAIL wait_hold pc=%0d busy=%0b ir_valid=%0b expected %0d 1 0",
                   pc_out, busy, ir_valid, pc_m);
        end
      end
      exec_done = 1'b1;
      {sign_in, zero_in, overflow_in, carry_in} = fl;
      tick();
      exec_done = 1'b0;
      fl_m = fl;
      pc_m = pc_m + AW'(1);
      ret_m++;
      cyc_m += 4 + k + dd;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ir_out !== 32'd0 || ir_valid !== 1'b0 || halted !== 1'b0 || busy !== 1'b0 ||
        pc_out !== 4'd0) begin
      errors++;
      $display("FAIL reset ir_out=%h ir_valid=%0b halted=%0b busy=%0b pc=%0d expected all 0",
               ir_out, ir_valid, halted, busy, pc_out);
    end
`ifdef INSTR_FETCH_PERF_CNT_EN
    checks++;
    if (retired_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf retired=%0d cycles=%0d expected 0 0", retired_cnt, cycle_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    bit h;
    do_reset();
    load(0, mk(5'b00010, 16'h1234), 1'b0);
    load(1, mk(5'b11001, 16'h0000), 1'b0);
    do_start();
    exec_one(0, 1, 4'b0000, 1'b0, 1'b0, h);
    checks++;
    if (pc_out !== 4'd1) begin
      errors++;
      $display("FAIL basic_pc pc=%0d expected 1", pc_out);
    end
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    checks++;
    if (halted !== 1'b1 || pc_out !== 4'd1) begin
      errors++;
      $display("FAIL basic_halt halted=%0b pc=%0d expected 1 1", halted, pc_out);
    end
  endtask

  task automatic test_backpressure();
    bit h;
    do_reset();
    load(0, mk(5'b00101, 16'hBEEF), 1'b0);
    load(1, mk(5'b11001, 16'h0000), 1'b0);
    do_start();
    exec_one(5, 0, 4'b1010, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
  endtask

  task automatic test_branch();
    bit h;
    do_reset();
    load(0, mk(5'b00001, 16'h0000), 1'b0);
    load(1, mk(5'b10101, 16'h0007), 1'b0);
    load(7, mk(5'b00011, 16'h0000), 1'b0);
    load(8, mk(5'b10101, 16'h0007), 1'b0);
    load(9, mk(5'b11001, 16'h0000), 1'b0);
    do_start();
    exec_one(0, 0, 4'b0100, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    checks++;
    if (pc_out !== 4'd7) begin
      errors++;
      $display("FAIL jzero_taken pc=%0d expected 7", pc_out);
    end
    exec_one(1, 0, 4'b1011, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    checks++;
    if (pc_out !== 4'd9) begin
      errors++;
      $display("FAIL jzero_not_taken pc=%0d expected 9", pc_out);
    end
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
  endtask

  task automatic test_wrap();
    bit h;
    do_reset();
    load(0, mk(5'b10110, 16'h00FF), 1'b0);
    load(15, mk(5'b00100, 16'h0000), 1'b0);
    load(1, mk(5'b10000, 16'h0013), 1'b0);
    load(3, mk(5'b11001, 16'h0000), 1'b0);
    do_start();
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    checks++;
    if (pc_out !== 4'd15) begin
      errors++;
      $display("FAIL imm_truncate pc=%0d expected 15", pc_out);
    end
    exec_one(0, 0, 4'b0100, 1'b0, 1'b0, h);
    checks++;
    if (pc_out !== 4'd0) begin
      errors++;
      $display("FAIL pc_wrap pc=%0d expected 0", pc_out);
    end
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    checks++;
    if (pc_out !== 4'd3) begin
      errors++;
      $display("FAIL jmp_0x13 pc=%0d expected 3", pc_out);
    end
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
  endtask

  task automatic test_guards();
    bit h;
    do_reset();
    load(0, mk(5'b00110, 16'h0A0A), 1'b0);
    load(1, mk(5'b00111, 16'h5050), 1'b0);
    load(2, mk(5'b11001, 16'h0000), 1'b0);
    do_start();
    exec_one(0, 2, 4'b0001, 1'b1, 1'b1, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    do_start();
    tick();
    tick();
    checks++;
    if (ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_issue ir_valid=%0b expected 1", ir_valid);
    end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    model_restart();
    checks++;
    if (ir_valid !== 1'b0 || pc_out !== 4'd0 || busy !== 1'b0 || halted !== 1'b0 ||
        ir_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_issue ir_valid=%0b pc=%0d busy=%0b halted=%0b expected 0 0 0 0",
               ir_valid, pc_out, busy, halted);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%0b ir_valid=%0b expected 0 0", busy, ir_valid);
    end
    do_start();
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
  endtask

`ifdef INSTR_FETCH_PERF_CNT_EN
  task automatic test_perf();
    bit h;
    do_reset();
    load(0, mk(5'b00010, 16'h0000), 1'b0);
    load(1, mk(5'b10000, 16'h0002), 1'b0);
    load(2, mk(5'b11001, 16'h0000), 1'b0);
    do_start();
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    exec_one(0, 0, 4'b0000, 1'b0, 1'b0, h);
    checks++;
    if (retired_cnt !== 32'd2 || cycle_cnt !== 32'd8) begin
      errors++;
      $display("FAIL perf_program retired=%0d cycles=%0d expected 2 8", retired_cnt, cycle_cnt);
    end
    do_start();
    checks++;
    if (retired_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_clear retired=%0d cycles=%0d expected 0 0", retired_cnt, cycle_cnt);
    end
  endtask
`endif

  task automatic test_random();
    bit h;
    int halts;
    for (int run = 0; run < 8; run++) begin
      do_reset();
      for (int a = 1; a < DEPTH; a++) load(a, rand_instr(), 1'b0);
      load(0, rand_instr(), 1'b1);
      halts = 0;
      for (int n = 0; n < 40; n++) begin
        exec_one($urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), h);
        if (h) begin
          halts++;
          if (halts > 2) break;
          load(0, rand_instr(), 1'b1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_wrap();
    test_guards();
`ifdef INSTR_FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Upstream fetch/sequencer stage that feeds the combinational execute/flag unit.
- Holds the program memory and PC, and fetches and decodes 32-bit instructions.
- Resolves conditional jumps internally using the condition flags latched from the last executed ALU instruction.
- Issues non-branch instructions to execute over a valid/ready handshake, then waits for completion.

Parameters:
- PROG_DEPTH, 16, program memory words (power of 2, >=2); AW = $clog2(PROG_DEPTH).
- IW, 32, instruction width; fields: opcode IR[31:27], immediate IR[15:0].

Ports:
- clk  in  1  system clock, rising edge
- sys_rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins execution from IDLE or HALT
- prog_we  in  1  program memory write enable
- prog_addr  in  AW  program write address
- prog_data  in  32  program write data
- ir_out  out  32  instruction presented to execute stage
- ir_valid  out  1  ir_out valid
- ir_ready  in  1  execute stage accepts ir_out
- exec_done  in  1  one-cycle pulse, execute stage finished; flags valid
- sign_in, zero_in, overflow_in, carry_in  in  1 each  flags from execute
- pc_out  out  AW  current PC
- busy  out  1  high in FETCH/DECODE/ISSUE/WAIT
- halted  out  1  high in HALT

Behaviour:
- Reset: pc=0, state=IDLE, ir_out=0, ir_valid=0, halted=0, busy=0, flag_reg{s,z,o,c}=0. Memory contents are not reset.
- Reset mid-operation: same values at the next edge; any handshake in flight is abandoned.
- Branch opcodes: 10000 jmp, 10001 jcarry, 10010 jnocarry, 10011 jsign, 10100 jnosign, 10101 jzero, 10110 jnozero, 10111 jovf, 11000 jnovf. Halt opcode: 11001.
- Condition mapping: jcarry uses c, jsign uses s, jzero uses z, jovf uses o; each "jno*" uses the inverse.
- Other opcodes (including 00000-01011 and undefined ones) are ALU ops and are issued to execute.
- FSM states: IDLE, FETCH, DECODE, ISSUE, WAIT, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: ir_reg <= mem[pc] (synchronous read) -> DECODE.
- DECODE, halt: -> HALT, halted=1; pc unchanged.
- DECODE, branch: taken -> pc <= IR[AW-1:0] (upper immediate bits ignored); not taken -> pc <= pc+1. Next state FETCH. Branches never reach execute; flags are not modified.
- DECODE, ALU op: ir_out <= ir_reg, ir_valid <= 1 -> ISSUE.
- ISSUE: ir_valid and ir_out held stable until ir_ready=1. On valid&&ready: ir_valid <= 0 -> WAIT.
- WAIT: on exec_done=1: flag_reg <= {sign_in, zero_in, overflow_in, carry_in}, pc <= pc+1 -> FETCH.
- exec_done outside WAIT is ignored.
- If exec_done arrives in the same cycle as the handshake, it is ignored; execute must pulse at least 1 cycle later.
- Minimum ALU instruction cost: 4 cycles. Branch cost: 2 cycles.
- PC wrap: pc+1 from PROG_DEPTH-1 wraps to 0.
- HALT: start=1 -> pc=0, flag_reg=0, halted=0 -> FETCH.
- start while busy: ignored.
- prog_we: accepted only in IDLE or HALT; ignored otherwise.
- prog_we and start in the same cycle: the write completes, and the FETCH in the next cycle reads the new data.

Optional Feature:
- Macro: INSTR_FETCH_PERF_CNT_EN.
- Defined: adds outputs retired_cnt[31:0] and cycle_cnt[31:0].
  - retired_cnt increments on each exec_done accepted in WAIT and on each branch decode.
  - cycle_cnt increments every cycle while busy=1.
  - Both saturate at 32'hFFFF_FFFF and clear on sys_rst or on start from HALT.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Reset, then load mem[0]=add (opcode 00010), mem[1]=halt; start; hold ir_ready=1; pulse exec_done 2 cycles after handshake -> ir_out=mem[0] with ir_valid for 1 cycle; pc 0->1; halted=1 with pc_out=1.
- Backpressure: hold ir_ready=0 for 5 cycles -> ir_valid stays 1 and ir_out stays stable all 5 cycles; single transfer when ready rises.
- Conditional branch: exec_done with zero_in=1; next instruction jzero imm=16'h0007 -> pc_out=7, no ir_valid. Repeat with zero_in=0 -> pc_out=prev+1.
- Wrap/truncation: PROG_DEPTH=16, ALU op at addr 15 -> next fetch at 0. jmp imm=16'h0013 -> pc_out=3.
- Guards: start and prog_we while in WAIT -> no state change, memory unchanged. sys_rst asserted in ISSUE -> ir_valid=0, pc=0, state IDLE next cycle, memory preserved.
- With INSTR_FETCH_PERF_CNT_EN: program {ALU, jmp->2, halt}, exec_done 1 cycle after handshake -> retired_cnt=2, cycle_cnt=8 at halt.
